// File: rtl/flux_merge_rr.sv
// flux_merge_rr: round-robin merge of FLUX show-ahead sources into one {id, data} stream with a single output register.
// Define FLUX_MERGE_FIXED_PRIO_EN for fixed lowest-index priority (no pointer state).
module flux_merge_rr #(
  parameter int DATA_WIDTH = 32,
  parameter int FLUX       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FLUX*DATA_WIDTH-1:0]         din,
  input  logic [FLUX-1:0]                    empty,
  output logic [FLUX-1:0]                    read,
  output logic [DATA_WIDTH+$clog2(FLUX)-1:0] dout,
  output logic                               write,
  input  logic                               full
);
  localparam int ID_W = $clog2(FLUX);
  logic                       ov_q, ov_d;
  logic [DATA_WIDTH+ID_W-1:0] od_q, od_d;
  logic [ID_W-1:0]            g;
  logic                       found, ld, gnt;
`ifdef FLUX_MERGE_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int k = FLUX - 1; k >= 0; k--)
      if (!empty[k]) begin
        found = 1'b1;
        g     = ID_W'(k);
      end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;
  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v >= FLUX ? v - FLUX : v);
  endfunction
  // Scan backwards so the last hit is the first requester at or after ptr.
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int k = FLUX - 1; k >= 0; k--)
      if (!empty[wrap(int'(ptr_q) + k)]) begin
        found = 1'b1;
        g     = wrap(int'(ptr_q) + k);
      end
  end
  always_comb ptr_d = gnt ? wrap(int'(g) + 1) : ptr_q;
`endif
  always_comb begin
    write = ov_q & ~full;
    ld    = ~ov_q | write;
    gnt   = ld & found & ~rst;
    read  = gnt ? FLUX'(1) << g : '0;
    ov_d  = ld ? gnt : ov_q;
    od_d  = gnt ? {g, din[g*DATA_WIDTH +: DATA_WIDTH]} : od_q;
    dout  = od_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
`ifndef FLUX_MERGE_FIXED_PRIO_EN
      ptr_q <= '0;
`endif
    end else begin
      ov_q  <= ov_d;
      od_q  <= od_d;
`ifndef FLUX_MERGE_FIXED_PRIO_EN
      ptr_q <= ptr_d;
`endif
    end
  end
endmodule
